// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank/show slots per digit, frame-aligned
// display updates through a valid/ready load port, optional leading-zero blanking.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    lzb_en,
   output logic [3:0]              dec_d,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [2:0]              digit_idx,
   output logic                    frame_done
);

   typedef enum logic {
      BLANK,
      SHOW
   } state_t;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_PRE  = CNT_W'(DWELL_CYCLES - 2);
   localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pend_flag;

   logic                    last_digit;
   logic                    boundary;
   logic [2:0]              next_idx;
   logic [4*NUM_DIGITS-1:0] shadow_next;
   logic [3:0]              next_code;
   logic                    nonzero_above;

   // The code for the upcoming slot is taken from the shadow as it will be after this
   // edge, so the first digit of a new frame already sees freshly applied data.
   always_comb begin
      last_digit    = (digit_idx == LAST_IDX);
      boundary      = (state == SHOW) && (cnt == DWELL_LAST) && last_digit;
      next_idx      = last_digit ? 3'd0 : digit_idx + 3'd1;
      shadow_next   = (boundary && pend_flag) ? pending : shadow;
      next_code     = 4'hF;
      nonzero_above = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j == int'(next_idx)) begin
            next_code = shadow_next[j*4 +: 4];
         end
         if ((j >= int'(next_idx)) && (shadow_next[j*4 +: 4] != 4'h0)) begin
            nonzero_above = 1'b1;
         end
      end
      if (lzb_en && (next_idx != 3'd0) && !nonzero_above) begin
         next_code = 4'hF;
      end
   end

   // frame_done is raised one edge early so it is high during the final SHOW cycle,
   // the cycle whose closing edge applies any pending frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BLANK;
         cnt        <= '0;
         an_n       <= '1;
         dec_d      <= 4'hF;
         digit_idx  <= 3'd0;
         frame_done <= 1'b0;
         load_ready <= 1'b1;
         shadow     <= '1;
         pending    <= '1;
         pend_flag  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
               state      <= SHOW;
               cnt        <= '0;
               an_n       <= ~(NUM_DIGITS'(1) << digit_idx);
               frame_done <= last_digit && (DWELL_CYCLES == 1);
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            if (cnt == DWELL_LAST) begin
               state     <= BLANK;
               cnt       <= '0;
               an_n      <= '1;
               digit_idx <= next_idx;
               dec_d     <= next_code;
               shadow    <= shadow_next;
            end else begin
               cnt        <= cnt + CNT_W'(1);
               frame_done <= last_digit && (cnt == DWELL_PRE);
            end
         end

         if (boundary && pend_flag) begin
            pend_flag  <= 1'b0;
            load_ready <= 1'b1;
         end else if (load_valid && load_ready) begin
            pending    <= load_data;
            pend_flag  <= 1'b1;
            load_ready <= 1'b0;
         end
      end
   end

endmodule
